// File: rtl/mux_pkg.sv
// Shared types for the scan_mux slice: controller states and mode encodings.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_ctr.sv
// Scan position tracker: current channel, dwell counter, clear-on-entry and
// detection of the first output of a new pass after a wrap.
module scan_ctr #(
  parameter  int CHANNELS = 4,
  parameter  int DWELL_W  = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_step,
  input  logic               i_clear,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [SEL_W-1:0]   o_cur,
  output logic               o_wrap
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]   r_cur;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_wrapped;
  logic [SEL_W-1:0]   w_cur;
  logic [DWELL_W-1:0] w_cnt;

  // On entry the stale position is ignored so the entry cycle itself shows channel 0.
  assign w_cur = i_clear ? '0 : r_cur;
  assign w_cnt = i_clear ? '0 : r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur     <= '0;
      r_cnt     <= '0;
      r_wrapped <= 1'b0;
    end else if (i_step) begin
      if (w_cnt >= i_dwell) begin
        r_cnt     <= '0;
        r_cur     <= (w_cur == LAST_CH) ? '0 : w_cur + 1'b1;
        r_wrapped <= (w_cur == LAST_CH);
      end else begin
        r_cnt     <= w_cnt + 1'b1;
        r_cur     <= w_cur;
        r_wrapped <= 1'b0;
      end
    end
  end

  assign o_cur  = w_cur;
  // r_wrapped marks that the channel now selected is the first one after a wrap.
  assign o_wrap = i_step && !i_clear && r_wrapped;

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel W-bit mux with manual select and dwell-timed scanning;
// every output word is tagged with the channel that produced it.
module scan_mux import mux_pkg::*; #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int DWELL_W  = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          y_ch,
  output logic                      y_valid,
  output logic                      wrap
);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_scan_step;
  logic               w_scan_clear;
  logic [SEL_W-1:0]   w_cur;
  logic               w_wrap;
  logic [SEL_W-1:0]   w_sel_clamped;
  logic [SEL_W-1:0]   w_ch;
  logic [WIDTH-1:0]   w_data;
  logic [WIDTH-1:0]   w_slice [CHANNELS];
  logic [WIDTH-1:0]   r_y;
  logic [SEL_W-1:0]   r_y_ch;
  logic               r_y_valid;
  logic               r_wrap;

  always_comb begin
    w_state_next = r_state;
    if (en) w_state_next = (mode == MODE_MANUAL) ? MANUAL : SCAN;
  end

  // The incoming mode, not the registered state, governs this cycle's output.
  assign w_scan_step  = en && (mode == MODE_SCAN);
  assign w_scan_clear = w_scan_step && (r_state != SCAN);

  scan_ctr #(
    .CHANNELS (CHANNELS),
    .DWELL_W  (DWELL_W)
  ) u_scan_ctr (
    .clk     (clk),
    .rst     (rst),
    .i_step  (w_scan_step),
    .i_clear (w_scan_clear),
    .i_dwell (dwell),
    .o_cur   (w_cur),
    .o_wrap  (w_wrap)
  );

  assign w_sel_clamped = (int'(sel) >= CHANNELS) ? SEL_W'(CHANNELS - 1) : sel;
  assign w_ch          = (mode == MODE_SCAN) ? w_cur : w_sel_clamped;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slice
      assign w_slice[gi] = d[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    w_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_ch == SEL_W'(k)) w_data = w_slice[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_y       <= '0;
      r_y_ch    <= '0;
      r_y_valid <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (en) begin
        r_y       <= w_data;
        r_y_ch    <= w_ch;
        r_y_valid <= 1'b1;
        r_wrap    <= w_wrap;
      end else begin
        r_y_valid <= 1'b0;
        r_wrap    <= 1'b0;
      end
    end
  end

  assign y       = r_y;
  assign y_ch    = r_y_ch;
  assign y_valid = r_y_valid;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench: a 4x4-bit and a 3x8-bit scan_mux share one stimulus
// stream and are each compared against a behavioural model every cycle.
module tb_scan_mux;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, mode;
  logic [1:0]  sel;
  logic [7:0]  dwell;
  logic [31:0] dv;

  logic [3:0]  a_y;
  logic [1:0]  a_ch;
  logic        a_valid, a_wrap;
  logic [7:0]  b_y;
  logic [1:0]  b_ch;
  logic        b_valid, b_wrap;

  scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .d(dv[15:0]), .y(a_y), .y_ch(a_ch), .y_valid(a_valid), .wrap(a_wrap)
  );

  scan_mux #(.WIDTH(8), .CHANNELS(3), .DWELL_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .d(dv[23:0]), .y(b_y), .y_ch(b_ch), .y_valid(b_valid), .wrap(b_wrap)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one entry per DUT (0 = 4x4, 1 = 3x8).
  int nch [2] = '{4, 3};
  int wid [2] = '{4, 8};
  bit m_scan [2];
  int m_cur [2], m_cnt [2], m_last [2];
  int e_y [2], e_ch [2], e_v [2], e_w [2];

  task automatic model(input int i);
    int ch;
    if (rst) begin
      m_scan[i] = 0; m_cur[i] = 0; m_cnt[i] = 0; m_last[i] = -1;
      e_y[i] = 0; e_ch[i] = 0; e_v[i] = 0; e_w[i] = 0;
    end else if (en) begin
      if (mode) begin
        if (!m_scan[i]) begin
          m_cur[i] = 0; m_cnt[i] = 0; m_last[i] = -1;
        end
        ch = m_cur[i];
        // wrap flags the first channel-0 word that follows the last channel
        e_w[i] = (ch == 0 && m_last[i] == nch[i] - 1) ? 1 : 0;
        m_last[i] = ch;
        if (m_cnt[i] >= int'(dwell)) begin
          m_cnt[i] = 0;
          m_cur[i] = (m_cur[i] + 1) % nch[i];
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end else begin
        ch = (int'(sel) > nch[i] - 1) ? nch[i] - 1 : int'(sel);
        e_w[i] = 0;
      end
      m_scan[i] = mode;
      e_ch[i] = ch;
      e_y[i] = int'((dv >> (ch * wid[i])) & ((32'd1 << wid[i]) - 32'd1));
      e_v[i] = 1;
    end else begin
      e_v[i] = 0;
      e_w[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model(0);
    model(1);
    #1;
    chk("a_y", a_y, e_y[0]);
    chk("a_ch", a_ch, e_ch[0]);
    chk("a_valid", a_valid, e_v[0]);
    chk("a_wrap", a_wrap, e_w[0]);
    chk("b_y", b_y, e_y[1]);
    chk("b_ch", b_ch, e_ch[1]);
    chk("b_valid", b_valid, e_v[1]);
    chk("b_wrap", b_wrap, e_w[1]);
  endtask

  int seq2 [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 2'd0; dwell = 8'd0; dv = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) m_last[i] = -1;
    tick();
    tick();
    chk("rst_a_y", a_y, 0);
    chk("rst_b_ch", b_ch, 0);
    chk("rst_a_valid", a_valid, 0);

    // Manual select straight out of reset
    rst = 1'b0; mode = 1'b0; sel = 2'd2; dv = 32'h0000_DCBA;
    tick();
    chk("tp_manual_y", a_y, 'hC);
    chk("tp_manual_ch", a_ch, 2);
    chk("tp_manual_valid", a_valid, 1);

    sel = 2'd3;
    tick();
    chk("tp_clamp_b_ch", b_ch, 2);

    // Scan with dwell 2
    mode = 1'b1; dwell = 8'd2;
    for (int k = 0; k < 13; k++) begin
      dv = $urandom;
      tick();
      chk("tp_dw2_a_ch", a_ch, seq2[k]);
      chk("tp_dw2_a_wrap", a_wrap, (k == 12) ? 1 : 0);
      chk("tp_dw2_b_ch", b_ch, (k / 3) % 3);
      chk("tp_dw2_b_wrap", b_wrap, (k == 9) ? 1 : 0);
    end

    // Scan with dwell 0, re-entered through manual
    mode = 1'b0; tick();
    mode = 1'b1; dwell = 8'd0;
    for (int k = 0; k < 8; k++) begin
      dv = $urandom;
      tick();
      chk("tp_dw0_a_ch", a_ch, k % 4);
      chk("tp_dw0_a_wrap", a_wrap, (k == 4) ? 1 : 0);
    end

    // Enable gap mid-dwell on channel 1
    mode = 1'b0; tick();
    mode = 1'b1; dwell = 8'd3;
    for (int k = 0; k < 5; k++) tick();
    chk("tp_gap_pre_ch", a_ch, 1);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dv = $urandom;
      tick();
      chk("tp_gap_valid", a_valid, 0);
      chk("tp_gap_hold_ch", a_ch, 1);
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tp_gap_resume_ch", a_ch, (k == 3) ? 2 : 1);
    end

    // Mode switch at channel 2, back to scan, reset at channel 3
    mode = 1'b0; sel = 2'd3;
    tick();
    chk("tp_sw_manual_ch", a_ch, 3);
    mode = 1'b1; dwell = 8'd0;
    tick();
    chk("tp_sw_rescan_ch", a_ch, 0);
    for (int k = 0; k < 3; k++) tick();
    chk("tp_sw_at3_ch", a_ch, 3);
    rst = 1'b1;
    tick();
    chk("tp_rst_valid", a_valid, 0);
    rst = 1'b0;
    tick();
    chk("tp_rst_restart_ch", a_ch, 0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) dwell = 8'($urandom_range(0, 4));
      sel = 2'($urandom);
      dv  = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
